// File: rtl/manchester_serdes.sv
// Serial Manchester transmitter and receiver on one clock, IEEE or Thomas polarity.
// TX serialises a handshaked word MSB-first; RX decodes, flags code violations and counts errored frames.
module manchester_serdes #(
    parameter int WIDTH           = 8,
    parameter int HALF_BIT_CYCLES = 4,
    parameter int ERR_CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_line,
    output logic                 tx_sof,
    output logic                 tx_busy,
    input  logic                 rx_line,
    input  logic                 rx_start,
    output logic [WIDTH-1:0]     rx_data,
    output logic                 rx_valid,
    output logic                 rx_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int HC_W  = $clog2(HALF_BIT_CYCLES);
    localparam int IDX_W = $clog2(2 * WIDTH);
    localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(HALF_BIT_CYCLES - 1);
    localparam logic [HC_W-1:0]  HC_MID   = HC_W'(HALF_BIT_CYCLES / 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2 * WIDTH - 1);

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
    typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;

    tx_state_t        tx_state, tx_state_next;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] tx_shift_adv;
    logic             tx_mode;
    logic [HC_W-1:0]  tx_cnt;
    logic [IDX_W-1:0] tx_idx;
    logic             tx_accept;
    logic             tx_half_end;
    logic             tx_frame_end;
    logic             tx_line_next;

    assign tx_accept    = (tx_state == TX_IDLE) && tx_valid;
    assign tx_half_end  = (tx_state == TX_SEND) && (tx_cnt == HC_LAST);
    assign tx_frame_end = tx_half_end && (tx_idx == IDX_LAST);
    assign tx_shift_adv = tx_shift << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_shift <= '0;
            tx_mode  <= 1'b0;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_line  <= 1'b0;
            tx_sof   <= 1'b0;
            tx_busy  <= 1'b0;
            tx_ready <= 1'b1;
        end else begin
            tx_state <= tx_state_next;
            tx_line  <= tx_line_next;
            tx_sof   <= tx_accept;
            tx_busy  <= (tx_state_next == TX_SEND);
            tx_ready <= (tx_state_next == TX_IDLE);
            if (tx_accept) begin
                tx_shift <= tx_data;
                tx_mode  <= mode;
                tx_cnt   <= '0;
                tx_idx   <= '0;
            end else if (tx_state == TX_SEND) begin
                if (tx_half_end) begin
                    tx_cnt <= '0;
                    tx_idx <= tx_idx + IDX_W'(1);
                    // The MSB leaves the shifter only once both its halves are on the line.
                    if (tx_idx[0]) tx_shift <= tx_shift_adv;
                end else begin
                    tx_cnt <= tx_cnt + HC_W'(1);
                end
            end
        end
    end

    always_comb begin
        tx_state_next = tx_state;
        case (tx_state)
            TX_IDLE: if (tx_valid) tx_state_next = TX_SEND;
            TX_SEND: if (tx_frame_end) tx_state_next = TX_IDLE;
            default: tx_state_next = TX_IDLE;
        endcase
    end

    // First half of a bit is bit^mode; the second half is always its complement.
    always_comb begin
        tx_line_next = 1'b0;
        case (tx_state)
            TX_IDLE: if (tx_valid) tx_line_next = tx_data[WIDTH-1] ^ mode;
            TX_SEND: begin
                if (!tx_half_end)      tx_line_next = tx_line;
                else if (tx_frame_end) tx_line_next = 1'b0;
                else if (!tx_idx[0])   tx_line_next = ~tx_line;
                else                   tx_line_next = tx_shift_adv[WIDTH-1] ^ tx_mode;
            end
            default: tx_line_next = 1'b0;
        endcase
    end

    rx_state_t          rx_state, rx_state_next;
    logic               rx_mode;
    logic [HC_W-1:0]    rx_cnt;
    logic [IDX_W-1:0]   rx_idx;
    logic               rx_first;
    logic [WIDTH-1:0]   rx_shift;
    logic               rx_viol;
    logic               rx_sample;
    logic               rx_pair;
    logic               rx_last;
    logic               rx_bad;
    logic               rx_bit;
    logic [WIDTH-1:0]   rx_shift_next;
    logic               rx_viol_next;
    logic               rx_valid_next;
    logic [WIDTH-1:0]   rx_data_next;
    logic               rx_err_next;
    logic [ERR_CNT_W-1:0] err_count_next;

    assign rx_sample     = (rx_state == RX_RECV) && !rx_start && (rx_cnt == HC_MID);
    assign rx_pair       = rx_sample && rx_idx[0];
    assign rx_last       = rx_pair && (rx_idx == IDX_LAST);
    assign rx_bad        = (rx_first == rx_line);
    assign rx_bit        = !rx_bad && (rx_first ^ rx_mode);
    assign rx_shift_next = (rx_shift << 1) | WIDTH'(rx_bit);
    assign rx_viol_next  = rx_viol | rx_bad;

    // rx_cnt/rx_idx track the offset from the rx_start cycle, so cnt==H/2 is mid half-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state  <= RX_IDLE;
            rx_mode   <= 1'b0;
            rx_cnt    <= '0;
            rx_idx    <= '0;
            rx_first  <= 1'b0;
            rx_shift  <= '0;
            rx_viol   <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            rx_err    <= 1'b0;
            err_count <= '0;
        end else begin
            rx_state  <= rx_state_next;
            rx_valid  <= rx_valid_next;
            rx_data   <= rx_data_next;
            rx_err    <= rx_err_next;
            err_count <= err_count_next;
            if (rx_start) begin
                rx_mode  <= mode;
                rx_cnt   <= HC_W'(1);
                rx_idx   <= '0;
                rx_first <= 1'b0;
                rx_shift <= '0;
                rx_viol  <= 1'b0;
            end else if (rx_state == RX_RECV) begin
                if (rx_cnt == HC_LAST) begin
                    rx_cnt <= '0;
                    rx_idx <= rx_idx + IDX_W'(1);
                end else begin
                    rx_cnt <= rx_cnt + HC_W'(1);
                end
                if (rx_sample && !rx_idx[0]) rx_first <= rx_line;
                if (rx_pair) begin
                    rx_shift <= rx_shift_next;
                    rx_viol  <= rx_viol_next;
                end
            end
        end
    end

    always_comb begin
        rx_state_next = rx_state;
        case (rx_state)
            RX_IDLE: if (rx_start) rx_state_next = RX_RECV;
            RX_RECV: if (!rx_start && rx_last) rx_state_next = RX_IDLE;
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_valid_next  = 1'b0;
        rx_data_next   = rx_data;
        rx_err_next    = rx_err;
        err_count_next = err_count;
        if (rx_last) begin
            rx_valid_next = 1'b1;
            rx_data_next  = rx_shift_next;
            rx_err_next   = rx_viol_next;
            if (rx_viol_next && (err_count != '1)) err_count_next = err_count + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_manchester_serdes.sv
// Self-checking bench for manchester_serdes: loopback vectors from a table, hand-driven RX corner cases,
// and a scoreboard of expected rx_valid results including the cycle each one must appear in.
module tb_manchester_serdes;

    logic       clk;
    logic       rst;
    logic       mode;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_line;
    logic       tx_sof;
    logic       tx_busy;
    logic       rx_line;
    logic       rx_start;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic [1:0] err_count;

    logic lb_en;
    logic rx_line_drv;
    logic rx_start_drv;
    int   cyc;
    int   n_checks;
    int   n_fail;

    typedef struct {
        logic [7:0]  data;
        logic        mode;
        logic [15:0] halves;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       err;
        logic [1:0] cnt;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];

    assign rx_line  = lb_en ? tx_line : rx_line_drv;
    assign rx_start = lb_en ? tx_sof  : rx_start_drv;

    manchester_serdes #(
        .WIDTH(8),
        .HALF_BIT_CYCLES(4),
        .ERR_CNT_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mode(mode),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_line(tx_line),
        .tx_sof(tx_sof),
        .tx_busy(tx_busy),
        .rx_line(rx_line),
        .rx_start(rx_start),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_err(rx_err),
        .err_count(err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Each rx_valid must match the oldest outstanding expectation, including its cycle.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_rx_valid: got rx_valid=1, expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("rx_data", 32'(rx_data), 32'(e.data));
                checkOutput("rx_err", 32'(rx_err), 32'(e.err));
                checkOutput("err_count", 32'(err_count), 32'(e.cnt));
                checkOutput("rx_valid_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic wait_ready();
        int i;
        i = 0;
        while (tx_ready !== 1'b1 && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (tx_ready !== 1'b1) checkOutput("tx_ready_timeout", 32'(tx_ready), 32'd1);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (sb.size() != 0 && i < 300) begin
            @(negedge clk);
            i++;
        end
        checkOutput("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic m, input logic [15:0] halves,
                                 input logic [1:0] exp_cnt);
        int n;
        wait_ready();
        tx_data  = d;
        tx_valid = 1'b1;
        mode     = m;
        n        = cyc;
        sb.push_back('{d, 1'b0, exp_cnt, n + 64});
        for (int c = n + 1; c <= n + 65; c++) begin
            @(negedge clk);
            if (c == n + 1) begin
                checkOutput("tx_sof_first", 32'(tx_sof), 32'd1);
                checkOutput("tx_busy_first", 32'(tx_busy), 32'd1);
                checkOutput("tx_ready_low", 32'(tx_ready), 32'd0);
                tx_valid = 1'b0;
                tx_data  = ~d;
            end
            if (c == n + 2) begin
                checkOutput("tx_sof_once", 32'(tx_sof), 32'd0);
                mode = ~m;
            end
            if ((c - n - 1) % 4 == 2 && c < n + 65)
                checkOutput("tx_line_half", 32'(tx_line), 32'(halves[15 - (c - n - 1) / 4]));
            if (c == n + 64) checkOutput("tx_busy_last", 32'(tx_busy), 32'd1);
            if (c == n + 65) begin
                checkOutput("tx_ready_back", 32'(tx_ready), 32'd1);
                checkOutput("tx_busy_done", 32'(tx_busy), 32'd0);
                checkOutput("tx_line_idle", 32'(tx_line), 32'd0);
            end
        end
        drain();
    endtask

    task automatic drive_rx(input logic [15:0] halves, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            rx_start_drv = (i == 0);
            rx_line_drv  = halves[15 - i / 4];
            @(negedge clk);
        end
        rx_start_drv = 1'b0;
        rx_line_drv  = 1'b0;
    endtask

    task automatic rx_frame(input logic [15:0] halves, input logic [7:0] d, input logic err,
                            input logic [1:0] exp_cnt);
        sb.push_back('{d, err, exp_cnt, cyc + 63});
        drive_rx(halves, 64);
        drain();
    endtask

    initial begin
        int n;
        vecs[0] = '{8'hA5, 1'b0, 16'h9966};
        vecs[1] = '{8'h3C, 1'b1, 16'hA55A};
        vecs[2] = '{8'h00, 1'b0, 16'h5555};
        vecs[3] = '{8'hFF, 1'b1, 16'h5555};
        vecs[4] = '{8'h81, 1'b1, 16'h6AA9};
        vecs[5] = '{8'hC3, 1'b0, 16'hA55A};

        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        mode         = 1'b0;
        tx_data      = 8'h00;
        tx_valid     = 1'b0;
        lb_en        = 1'b0;
        rx_line_drv  = 1'b0;
        rx_start_drv = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_tx_ready", 32'(tx_ready), 32'd1);
        checkOutput("rst_tx_line", 32'(tx_line), 32'd0);
        checkOutput("rst_tx_sof", 32'(tx_sof), 32'd0);
        checkOutput("rst_tx_busy", 32'(tx_busy), 32'd0);
        checkOutput("rst_rx_data", 32'(rx_data), 32'd0);
        checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("rst_rx_err", 32'(rx_err), 32'd0);
        checkOutput("rst_err_count", 32'(err_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        lb_en = 1'b1;
        for (int i = 0; i < 6; i++) applyStimulus(vecs[i].data, vecs[i].mode, vecs[i].halves, 2'd0);

        // All-ones line: every pair is a violation, decoded word is zero.
        lb_en = 1'b0;
        mode  = 1'b0;
        rx_frame(16'hFFFF, 8'h00, 1'b1, 2'd1);
        lb_en = 1'b1;
        applyStimulus(8'hA5, 1'b0, 16'h9966, 2'd1);

        // Back-to-back words with tx_valid held; mode flips mid-frame.
        wait_ready();
        tx_data  = 8'h01;
        tx_valid = 1'b1;
        mode     = 1'b0;
        n        = cyc;
        sb.push_back('{8'h01, 1'b0, 2'd1, n + 64});
        for (int c = n + 1; c <= n + 66; c++) begin
            @(negedge clk);
            if (c == n + 1) begin
                checkOutput("b2b_sof1", 32'(tx_sof), 32'd1);
                tx_data = 8'hFF;
            end
            if (c == n + 20) mode = 1'b1;
            if (c == n + 22) checkOutput("b2b_line_unaffected", 32'(tx_line), 32'd1);
            if (c == n + 30) checkOutput("b2b_busy_ignores_valid", 32'(tx_ready), 32'd0);
            if (c == n + 65) begin
                checkOutput("b2b_ready", 32'(tx_ready), 32'd1);
                checkOutput("b2b_sof_gap", 32'(tx_sof), 32'd0);
                sb.push_back('{8'hFF, 1'b0, 2'd1, c + 64});
            end
            if (c == n + 66) begin
                checkOutput("b2b_sof2", 32'(tx_sof), 32'd1);
                tx_valid = 1'b0;
            end
        end
        drain();

        // Reset 20 cycles into a frame discards it.
        mode = 1'b0;
        wait_ready();
        tx_data  = 8'h96;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_tx_line", 32'(tx_line), 32'd0);
        checkOutput("midrst_tx_ready", 32'(tx_ready), 32'd1);
        checkOutput("midrst_tx_busy", 32'(tx_busy), 32'd0);
        checkOutput("midrst_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("midrst_err_count", 32'(err_count), 32'd0);
        rst = 1'b0;
        repeat (70) @(negedge clk);
        applyStimulus(8'h96, 1'b0, 16'h9669, 2'd0);

        // rx_start re-pulsed 30 cycles in restarts the frame.
        lb_en = 1'b0;
        mode  = 1'b0;
        drive_rx(16'hAAAA, 30);
        rx_frame(16'h6699, 8'h5A, 1'b0, 2'd0);

        // Errored frames saturate the 2-bit counter.
        rx_frame(16'hFFFF, 8'h00, 1'b1, 2'd1);
        rx_frame(16'h7699, 8'h1A, 1'b1, 2'd2);
        rx_frame(16'hFFFF, 8'h00, 1'b1, 2'd3);
        rx_frame(16'h0000, 8'h00, 1'b1, 2'd3);
        rx_frame(16'hFFFF, 8'h00, 1'b1, 2'd3);
        rx_frame(16'h6699, 8'h5A, 1'b0, 2'd3);

        repeat (10) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/manchester_serdes.md
Name: manchester_serdes

Overview:
Parametrised serial Manchester transmitter and receiver sharing one clock, generalising the team's 8-bit parallel IEEE/Thomas encoder/decoder.
- TX: accepts a WIDTH-bit word over a valid/ready handshake and serialises it MSB-first as Manchester half-bits on a single line.
- RX: re-samples such a line, decodes it, flags code violations and counts errored frames.
- Sits between byte-level logic and a single-wire link; TX and RX run independently and can be looped back.

Parameters:
- WIDTH, 8, data bits per frame (>=1).
- HALF_BIT_CYCLES, 4, clock cycles per Manchester half-bit (>=2).
- ERR_CNT_W, 8, width of the saturating errored-frame counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- mode  input  1  0 = IEEE (bit 1 -> halves 1,0; bit 0 -> 0,1); 1 = Thomas (bit 1 -> 0,1; bit 0 -> 1,0)
- tx_data  input  WIDTH  word to transmit
- tx_valid  input  1  tx_data valid
- tx_ready  output  1  TX idle, can accept
- tx_line  output  1  serial Manchester output
- tx_sof  output  1  one-cycle pulse on first cycle of a frame's first half-bit
- tx_busy  output  1  frame in progress
- rx_line  input  1  serial Manchester input
- rx_start  input  1  one-cycle pulse aligned with first cycle of first half-bit
- rx_data  output  WIDTH  last decoded word
- rx_valid  output  1  one-cycle pulse, rx_data/rx_err updated
- rx_err  output  1  last frame had at least one code violation
- err_count  output  ERR_CNT_W  saturating count of errored frames

Behaviour:
- Reset values: tx_ready=1, tx_line=0, tx_sof=0, tx_busy=0, rx_data=0, rx_valid=0, rx_err=0, err_count=0. Both FSMs return to IDLE. An in-flight frame is discarded with no rx_valid.
- All outputs are registered.
- H = HALF_BIT_CYCLES.

TX FSM (IDLE, SEND):
- Accept when tx_valid && tx_ready in cycle N. Latch tx_data and mode; later changes to mode or tx_data do not affect the frame.
- Half-bit k (0..2*WIDTH-1) drives tx_line during cycles N+1+k*H .. N+k*H+H.
- Bit order is MSB first. Half-bit 2i is the first half of data bit WIDTH-1-i.
- tx_sof=1 only in cycle N+1. tx_busy=1 during cycles N+1 .. N+2*WIDTH*H. tx_ready=0 from N+1 through N+2*WIDTH*H.
- tx_ready returns to 1 at cycle N+2*WIDTH*H+1. tx_line returns to 0 there unless a new word is accepted.
- A word held on tx_valid is accepted at that cycle, giving the next tx_sof at N+2*WIDTH*H+2.
- tx_valid while busy is ignored (no accept, no corruption).

RX FSM (IDLE, RECV):
- rx_start in cycle S latches mode and clears the half-bit index, shift register and violation flag.
- Half-bit k is sampled at cycle S+k*H+floor(H/2).
- After each pair of samples (a,b):
  - IEEE: 10 -> 1, 01 -> 0.
  - Thomas: 01 -> 1, 10 -> 0.
  - 00 or 11 -> shift in 0 and set the violation flag.
- The last sample is at cycle S+(2*WIDTH-1)*H+floor(H/2). In the following cycle:
  - rx_valid=1 for one cycle.
  - rx_data updated to the decoded word.
  - rx_err updated to the violation flag.
  - err_count increments if rx_err, saturating at all-ones.
- rx_data and rx_err hold until the next rx_valid.
- rx_start during RECV aborts the current frame with no rx_valid and restarts timing from that cycle.
- rx_line is ignored in IDLE.

Loopback contract:
- With rx_line=tx_line and rx_start=tx_sof, each accepted word appears on rx_data with rx_err=0.
- rx_valid occurs at S+(2*WIDTH-1)*H+floor(H/2)+1, where S is the tx_sof cycle.

Test Plan:
- Loopback, WIDTH=8, H=4, mode=0, tx_data=8'hA5 accepted at N:
  - tx_line halves are 10 01 10 01 01 10 01 10.
  - tx_sof at N+1; tx_ready=1 again at N+65.
  - rx_valid at N+64 (S=N+1, 1+62+1) with rx_data=8'hA5, rx_err=0, err_count=0.
- Same setup, mode=1, tx_data=8'h3C:
  - tx_line halves are 10 10 01 01 01 01 10 10.
  - rx_data=8'h3C, rx_err=0.
- Violation: rx_start pulse, then rx_line held 1 for 64 cycles, mode=0:
  - rx_valid with rx_data=8'h00, rx_err=1, err_count=1.
  - A following clean loopback frame gives rx_err=0 and err_count stays 1.
- Back-to-back: tx_valid held high with 8'h01 then 8'hFF:
  - Second accept at N+65, second tx_sof at N+66.
  - rx_data sequence is 8'h01 then 8'hFF; mode toggled mid-frame has no effect on the frame in flight.
- Reset at cycle N+20 of a frame:
  - Next cycle: tx_line=0, tx_ready=1, tx_busy=0, no rx_valid, err_count=0.
  - A new word afterwards transfers correctly.
- rx_start re-pulsed 30 cycles into a frame, with a fresh 8'h5A frame from that point:
  - Exactly one rx_valid, with rx_data=8'h5A.
  - Saturation: ERR_CNT_W=2 with 5 errored frames -> err_count=3.
